// File: rtl/add8_stream_accum.sv
// Purpose: sums GROUP operands (or fewer, closed by in_last) mod 2^WIDTH and counts carry-outs.
// Latency: result registered, valid exactly one cycle after the closing operand is accepted.
// Backpressure: a held result stalls input; a new group may start in the cycle the result retires.
module add8_stream_accum #(
    parameter int WIDTH = 8,
    parameter int GROUP = 4,
    parameter int CW    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_sum,
    output logic [CW-1:0]              out_carries,
    output logic [$clog2(GROUP+1)-1:0] out_count
);

    localparam int CNTW = $clog2(GROUP + 1);

    typedef enum logic {ACC, HOLD} state_t;

    state_t          state;
    logic [WIDTH-1:0] acc;
    logic [CNTW-1:0]  cnt;
    logic [CW-1:0]    carries;

    logic             accept;
    logic             close;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] nxt_acc;
    logic [CW-1:0]    nxt_carries;
    logic [CNTW-1:0]  nxt_cnt;

    assign in_ready = (state == ACC) || out_ready;
    assign accept   = in_valid && in_ready;
    assign close    = accept && (in_last || (cnt == CNTW'(GROUP - 1)));
    assign sum_ext  = {1'b0, acc} + {1'b0, in_data};
    assign nxt_cnt  = cnt + CNTW'(1);

    // First operand of a group loads directly; the carry counter sticks at all-ones.
    always_comb begin
        nxt_acc     = sum_ext[WIDTH-1:0];
        nxt_carries = carries;
        if (cnt == '0) begin
            nxt_acc     = in_data;
            nxt_carries = '0;
        end else if (sum_ext[WIDTH] && (carries != {CW{1'b1}})) begin
            nxt_carries = carries + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ACC;
            acc         <= '0;
            cnt         <= '0;
            carries     <= '0;
            out_valid   <= 1'b0;
            out_sum     <= '0;
            out_carries <= '0;
            out_count   <= '0;
        end else begin
            if ((state == HOLD) && out_ready) begin
                state     <= ACC;
                out_valid <= 1'b0;
            end
            if (accept) begin
                acc     <= nxt_acc;
                carries <= nxt_carries;
                if (close) begin
                    cnt         <= '0;
                    state       <= HOLD;
                    out_valid   <= 1'b1;
                    out_sum     <= nxt_acc;
                    out_carries <= nxt_carries;
                    out_count   <= nxt_cnt;
                end else begin
                    cnt <= nxt_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_add8_stream_accum.sv
// Directed-vector bench for add8_stream_accum with GROUP=4, WIDTH=8, CW=4.
module tb_add8_stream_accum;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic [3:0] out_carries;
    logic [2:0] out_count;

    int errors = 0;
    int checks = 0;

    add8_stream_accum #(.WIDTH(8), .GROUP(4), .CW(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_carries (out_carries),
        .out_count   (out_count)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic push(input logic [7:0] d, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL push_timeout data=%02h in_ready=%0b required 1", d, in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) idle_cycle();
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 8'h00 || out_carries !== 4'h0 ||
            out_count !== 3'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got v=%0b s=%02h c=%0d n=%0d rdy=%0b required 0 00 0 0 1",
                     out_valid, out_sum, out_carries, out_count, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_group();
        push(8'h10, 1'b0);
        push(8'h20, 1'b0);
        push(8'h30, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL early_valid got %0b required 0", out_valid);
        end
        push(8'h40, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'hA0 || out_carries !== 4'd0 || out_count !== 3'd4) begin
            errors++;
            $display("FAIL basic_group got v=%0b s=%02h c=%0d n=%0d required 1 a0 0 4",
                     out_valid, out_sum, out_carries, out_count);
        end
        idle_cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_retire got v=%0b required 0", out_valid);
        end
    endtask

    task automatic test_carries();
        repeat (4) push(8'hFF, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'hFC || out_carries !== 4'd3 || out_count !== 3'd4) begin
            errors++;
            $display("FAIL carries got v=%0b s=%02h c=%0d n=%0d required 1 fc 3 4",
                     out_valid, out_sum, out_carries, out_count);
        end
        idle_cycle();
    endtask

    task automatic test_last();
        push(8'h05, 1'b0);
        push(8'h07, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'h0C || out_carries !== 4'd0 || out_count !== 3'd2) begin
            errors++;
            $display("FAIL early_last got v=%0b s=%02h c=%0d n=%0d required 1 0c 0 2",
                     out_valid, out_sum, out_carries, out_count);
        end
        push(8'h01, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'h01 || out_count !== 3'd1) begin
            errors++;
            $display("FAIL clean_restart got v=%0b s=%02h n=%0d required 1 01 1",
                     out_valid, out_sum, out_count);
        end
        idle_cycle();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        push(8'h33, 1'b0);
        push(8'h44, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 8'hAA || out_count !== 3'd4) begin
                errors++;
                $display("FAIL hold_cycle%0d got rdy=%0b v=%0b s=%02h n=%0d required 0 1 aa 4",
                         i, in_ready, out_valid, out_sum, out_count);
            end
            idle_cycle();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release_ready got %0b required 1", in_ready);
        end
        idle_cycle();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_retire got v=%0b required 0", out_valid);
        end
        push(8'h01, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'h56 || out_count !== 3'd2) begin
            errors++;
            $display("FAIL same_cycle_accept got v=%0b s=%02h n=%0d required 1 56 2",
                     out_valid, out_sum, out_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_last   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d = 8'h80 + 8'(i);
            in_data = d;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready%0d got %0b required 1", i, in_ready);
            end
            idle_cycle();
            checks++;
            if (out_valid !== 1'b1 || out_sum !== d || out_count !== 3'd1 || out_carries !== 4'd0) begin
                errors++;
                $display("FAIL b2b_result%0d got v=%0b s=%02h n=%0d c=%0d required 1 %02h 1 0",
                         i, out_valid, out_sum, out_count, out_carries, d);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        idle_cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain got v=%0b required 0", out_valid);
        end
    endtask

    task automatic test_mid_reset();
        push(8'h50, 1'b0);
        push(8'h60, 1'b0);
        rst_n = 1'b0;
        idle_cycle();
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 8'h00 || out_carries !== 4'h0 ||
            out_count !== 3'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset got v=%0b s=%02h c=%0d n=%0d rdy=%0b required 0 00 0 0 1",
                     out_valid, out_sum, out_carries, out_count, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) push(8'h01, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_early got v=%0b required 0", out_valid);
        end
        push(8'h01, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'h04 || out_carries !== 4'd0 || out_count !== 3'd4) begin
            errors++;
            $display("FAIL post_reset_group got v=%0b s=%02h c=%0d n=%0d required 1 04 0 4",
                     out_valid, out_sum, out_carries, out_count);
        end
        idle_cycle();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic_group();
        test_carries();
        test_last();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
